rv32f_fpu_scheduler: RTL and testbench

RV32F_FPU_SCHEDULER -- requirements
Module: rv32f_fpu_scheduler

---
 rtl/rv32f_fpu_scheduler_if.sv | 66 ++++++
 rtl/rv32f_fpu_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rv32f_fpu_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32f_fpu_scheduler_if.sv
// rv32f_fpu_scheduler_if
//   Bundles every non-clock/reset signal of the RV32F FP scheduler.
//   Modports:
//     slave  - the scheduler itself. It receives decoded ops and CSR
//              accesses, and drives the execution units and writeback.
//     master - the surrounding core/environment. It issues ops, returns
//              unit results and consumes writebacks.
//   Signal groups:
//     in_*   - decoded FP op handshake (valid/ready)
//     pipe_* - pipelined add/mul/FMA/misc unit (fixed latency)
//     div_*  - iterative div/sqrt unit (start/done)
//     wb_*   - FP register-file write port (no backpressure)
//     csr_*  - fflags/frm/fcsr access, illegal-op pulse
interface rv32f_fpu_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [6:0]  in_funct7;
  logic [2:0]  in_rm;
  logic [4:0]  in_rd;

  logic        pipe_issue;
  logic [2:0]  pipe_rm;
  logic [31:0] pipe_result;
  logic [4:0]  pipe_flags;

  logic        div_start;
  logic [2:0]  div_rm;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_flags;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct7, in_rm, in_rd,
    output in_ready,
    output pipe_issue, pipe_rm,
    input  pipe_result, pipe_flags,
    output div_start, div_rm,
    input  div_done, div_result, div_flags,
    output wb_valid, wb_rd, wb_data,
    input  csr_wr_en, csr_addr, csr_wdata,
    output csr_rdata, illegal
  );

  modport master (
    output in_valid, in_opcode, in_funct7, in_rm, in_rd,
    input  in_ready,
    input  pipe_issue, pipe_rm,
    output pipe_result, pipe_flags,
    input  div_start, div_rm,
    output div_done, div_result, div_flags,
    input  wb_valid, wb_rd, wb_data,
    output csr_wr_en, csr_addr, csr_wdata,
    input  csr_rdata, illegal
  );
endinterface

// File: rtl/rv32f_fpu_scheduler.sv
// rv32f_fpu_scheduler
//   Issue/writeback scheduler for the RV32F execution units.
//   Decoded ops are classified and dispatched to one of two units:
//     - a fixed-latency pipelined unit (add/mul/FMA/misc)
//     - an iterative div/sqrt unit
//   Writebacks from both units are merged onto a single register-file
//   write port. The block also owns the fflags/frm CSRs.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-low reset
//     bus - rv32f_fpu_scheduler_if.slave (op handshake, unit interfaces,
//           writeback, CSR access, illegal pulse)
//   Parameter:
//     PIPE_LATENCY - cycles from pipe_issue to pipe_result being valid (1..8)
//   Configuration macro:
//     RV32F_SCHED_DIVSQRT_EN - when defined, FDIV.S/FSQRT.S are dispatched
//     to the div unit. Otherwise they are reported illegal, the div outputs
//     are tied low and the div inputs are ignored.
module rv32f_fpu_scheduler #(
  parameter int PIPE_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  rv32f_fpu_scheduler_if.slave        bus
);

  localparam logic [6:0] OPC_FMADD  = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD = 7'b1001111;
  localparam logic [6:0] OPC_FP_OP  = 7'b1010011;
  localparam logic [6:0] F7_FDIV    = 7'b0001100;
  localparam logic [6:0] F7_FSQRT   = 7'b0101100;

  logic [4:0]              fflags;
  logic [2:0]              frm;
  logic [4:0]              fflags_nxt;
  logic [2:0]              frm_nxt;

  // Valid bits and destination registers of ops in flight in the pipe unit.
  // Index 0 is the entry written at issue; the last index is the tail.
  logic [PIPE_LATENCY-1:0] sr_valid;
  logic [4:0]              sr_rd [PIPE_LATENCY];
  logic                    tail_valid;

  logic                    is_divsqrt;
  logic                    is_pipe_opc;
  logic [2:0]              rm_res;
  logic                    rm_bad;
  logic                    pipe_sel;
  logic                    div_sel;
  logic                    op_illegal;
  logic                    waw_sr;
  logic                    div_blocked;
  logic                    div_rd_hit;
  logic                    ready_int;
  logic                    accept;

  logic                    wb_valid_int;
  logic [4:0]              wb_rd_int;
  logic [31:0]             wb_data_int;
  logic [4:0]              wb_flags;

  assign tail_valid = sr_valid[PIPE_LATENCY-1];

  // Decode: split ops into pipe/div/illegal.
  // A dynamic rounding mode resolves through frm before the legality check.
  always_comb begin
    is_divsqrt  = (bus.in_opcode == OPC_FP_OP) &&
                  ((bus.in_funct7 == F7_FDIV) || (bus.in_funct7 == F7_FSQRT));
    is_pipe_opc = (bus.in_opcode == OPC_FMADD)  || (bus.in_opcode == OPC_FMSUB) ||
                  (bus.in_opcode == OPC_FNMSUB) || (bus.in_opcode == OPC_FNMADD) ||
                  (bus.in_opcode == OPC_FP_OP);
    rm_res      = (bus.in_rm == 3'b111) ? frm : bus.in_rm;
    rm_bad      = (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
    pipe_sel    = is_pipe_opc && !is_divsqrt && !rm_bad;
`ifdef RV32F_SCHED_DIVSQRT_EN
    div_sel     = is_divsqrt && !rm_bad;
`else
    div_sel     = 1'b0;
`endif
    op_illegal  = !pipe_sel && !div_sel;
  end

  // A div/sqrt result must not be overtaken by a pipe op still in flight
  // to the same register.
  always_comb begin
    waw_sr = 1'b0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      if (sr_valid[i] && (sr_rd[i] == bus.in_rd)) begin
        waw_sr = 1'b1;
      end
    end
  end

  // Handshake. Reset forces in_ready low so nothing is accepted.
  // Illegal ops are consumed like any other op.
  assign ready_int = rst && !div_rd_hit && !(div_sel && (div_blocked || waw_sr));
  assign accept    = bus.in_valid && ready_int;

  assign bus.in_ready   = ready_int;
  assign bus.pipe_issue = accept && pipe_sel;
  assign bus.pipe_rm    = rm_res;
  assign bus.illegal    = accept && op_illegal;

  // Pipe tracking shift register.
  // It carries only {valid, rd}; the data itself comes back from the unit
  // at the tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_valid <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        sr_rd[i] <= 5'd0;
      end
    end else begin
      sr_valid[0] <= accept && pipe_sel;
      sr_rd[0]    <= bus.in_rd;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_rd[i]    <= sr_rd[i-1];
      end
    end
  end

`ifdef RV32F_SCHED_DIVSQRT_EN
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

  div_state_t  div_state;
  logic [4:0]  div_rd;
  logic        buf_valid;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;
  logic [4:0]  buf_flags;

  assign div_blocked   = (div_state == DIV_BUSY) || buf_valid;
  assign div_rd_hit    = ((div_state == DIV_BUSY) && (div_rd == bus.in_rd)) ||
                         (buf_valid && (buf_rd == bus.in_rd));
  assign bus.div_start = accept && div_sel;
  assign bus.div_rm    = (accept && div_sel) ? rm_res : 3'b000;

  // Div FSM and 1-entry result buffer.
  // A div_done that collides with a pipe tail is parked in the buffer.
  // Otherwise it goes straight to writeback. New div ops are held off
  // while the buffer is occupied, so capture and drain never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_state <= DIV_IDLE;
      div_rd    <= 5'd0;
      buf_valid <= 1'b0;
      buf_rd    <= 5'd0;
      buf_data  <= 32'd0;
      buf_flags <= 5'd0;
    end else begin
      if (buf_valid && !tail_valid) begin
        buf_valid <= 1'b0;
      end
      case (div_state)
        DIV_IDLE: begin
          if (accept && div_sel) begin
            div_state <= DIV_BUSY;
            div_rd    <= bus.in_rd;
          end
        end
        DIV_BUSY: begin
          if (bus.div_done) begin
            div_state <= DIV_IDLE;
            if (tail_valid) begin
              buf_valid <= 1'b1;
              buf_rd    <= div_rd;
              buf_data  <= bus.div_result;
              buf_flags <= bus.div_flags;
            end
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end
`else
  assign div_blocked   = 1'b0;
  assign div_rd_hit    = 1'b0;
  assign bus.div_start = 1'b0;
  assign bus.div_rm    = 3'b000;
`endif

  // Writeback arbitration. The pipe tail always wins. Otherwise the
  // buffered div result drains first, then a div result arriving this
  // very cycle.
  always_comb begin
    wb_valid_int = 1'b0;
    wb_rd_int    = 5'd0;
    wb_data_int  = 32'd0;
    wb_flags     = 5'd0;
    if (rst) begin
      if (tail_valid) begin
        wb_valid_int = 1'b1;
        wb_rd_int    = sr_rd[PIPE_LATENCY-1];
        wb_data_int  = bus.pipe_result;
        wb_flags     = bus.pipe_flags;
      end
`ifdef RV32F_SCHED_DIVSQRT_EN
      else if (buf_valid) begin
        wb_valid_int = 1'b1;
        wb_rd_int    = buf_rd;
        wb_data_int  = buf_data;
        wb_flags     = buf_flags;
      end else if ((div_state == DIV_BUSY) && bus.div_done) begin
        wb_valid_int = 1'b1;
        wb_rd_int    = div_rd;
        wb_data_int  = bus.div_result;
        wb_flags     = bus.div_flags;
      end
`endif
    end
  end

  assign bus.wb_valid = wb_valid_int;
  assign bus.wb_rd    = wb_rd_int;
  assign bus.wb_data  = wb_data_int;

  // CSR update. A software write lands first.
  // Exception flags from a coincident writeback are then accumulated on
  // top, so they are never lost.
  always_comb begin
    fflags_nxt = fflags;
    frm_nxt    = frm;
    if (bus.csr_wr_en) begin
      case (bus.csr_addr)
        12'h001: fflags_nxt = bus.csr_wdata[4:0];
        12'h002: frm_nxt    = bus.csr_wdata[2:0];
        12'h003: begin
          fflags_nxt = bus.csr_wdata[4:0];
          frm_nxt    = bus.csr_wdata[7:5];
        end
        default: ;
      endcase
    end
    if (wb_valid_int) begin
      fflags_nxt = fflags_nxt | wb_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fflags <= 5'd0;
      frm    <= 3'd0;
    end else begin
      fflags <= fflags_nxt;
      frm    <= frm_nxt;
    end
  end

  always_comb begin
    case (bus.csr_addr)
      12'h001: bus.csr_rdata = {27'd0, fflags};
      12'h002: bus.csr_rdata = {29'd0, frm};
      12'h003: bus.csr_rdata = {24'd0, frm, fflags};
      default: bus.csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_rv32f_fpu_scheduler.sv
// tb_rv32f_fpu_scheduler
//   Directed testbench for rv32f_fpu_scheduler with PIPE_LATENCY = 4.
//   Inputs change 1 time unit after each rising edge.
//   Outputs are sampled 1 time unit later.
//   Div-path scenarios follow RV32F_SCHED_DIVSQRT_EN. Without it, the bench
//   checks instead that FDIV/FSQRT are reported as illegal.
module tb_rv32f_fpu_scheduler;

  localparam logic [6:0] OPC_FP   = 7'b1010011;
  localparam logic [6:0] OPC_BAD  = 7'b0110011;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_MUL   = 7'b0001000;
  localparam logic [6:0] F7_DIV   = 7'b0001100;
  localparam logic [6:0] F7_SQRT  = 7'b0101100;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rv32f_fpu_scheduler_if bus ();

  rv32f_fpu_scheduler #(.PIPE_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_opcode   = OPC_FP;
    bus.in_funct7   = F7_ADD;
    bus.in_rm       = 3'b000;
    bus.in_rd       = 5'd0;
    bus.pipe_result = 32'd0;
    bus.pipe_flags  = 5'd0;
    bus.div_done    = 1'b0;
    bus.div_result  = 32'd0;
    bus.div_flags   = 5'd0;
    bus.csr_wr_en   = 1'b0;
    bus.csr_addr    = 12'h000;
    bus.csr_wdata   = 32'd0;
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [6:0] f7,
                        input logic [2:0] rm, input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = opc;
    bus.in_funct7 = f7;
    bus.in_rm     = rm;
    bus.in_rd     = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    set_op(OPC_FP, F7_ADD, 3'b000, 5'd1);
    bus.csr_addr = 12'h003;
    tick();
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.pipe_issue !== 1'b0) begin n_bad++; $display("FAIL rst_pipe_issue got %b want 0", bus.pipe_issue); end
    n_cmp++; if (bus.div_start !== 1'b0) begin n_bad++; $display("FAIL rst_div_start got %b want 0", bus.div_start); end
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid got %b want 0", bus.wb_valid); end
    n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got %b want 0", bus.illegal); end
    n_cmp++; if ({bus.wb_rd, bus.wb_data} !== 37'd0) begin n_bad++; $display("FAIL rst_wb_bus got %h/%h want 0", bus.wb_rd, bus.wb_data); end
    n_cmp++; if (bus.csr_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_fcsr got %h want 0", bus.csr_rdata); end
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
  endtask

  // Four back-to-back FADDs; writebacks land on cycles 4..7 in order.
  task automatic test_back_to_back();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c < 4) set_op(OPC_FP, F7_ADD, 3'b000, 5'(c + 1));
      if (c >= 4 && c < 8) bus.pipe_result = 32'h3F80_0000 + 32'(c - 4);
      #1;
      if (c < 4) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", c, bus.in_ready); end
        n_cmp++; if (bus.pipe_issue !== 1'b1) begin n_bad++; $display("FAIL b2b_issue[%0d] got %b want 1", c, bus.pipe_issue); end
      end
      if (c >= 4 && c < 8) begin
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'(c - 3) || bus.wb_data !== 32'h3F80_0000 + 32'(c - 4)) begin
          n_bad++;
          $display("FAIL b2b_wb[%0d] got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                   c, bus.wb_valid, bus.wb_rd, bus.wb_data, c - 3, 32'h3F80_0000 + 32'(c - 4));
        end
      end else begin
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_nowb[%0d] got %b want 0", c, bus.wb_valid); end
      end
      tick();
    end
  endtask

`ifdef RV32F_SCHED_DIVSQRT_EN
  // A div_done coincides with the pipe tail of rd=6.
  // The pipe result goes out first; the div result follows a cycle later.
  task automatic test_div_collision();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) set_op(OPC_FP, F7_DIV, 3'b000, 5'd5);
      if (c == 1) set_op(OPC_FP, F7_ADD, 3'b000, 5'd6);
      if (c == 5) begin
        bus.div_done    = 1'b1;
        bus.div_result  = 32'hD1D1_0005;
        bus.div_flags   = 5'b01000;
        bus.pipe_result = 32'hADD0_0006;
        bus.pipe_flags  = 5'b00001;
      end
      bus.csr_addr = 12'h001;
      #1;
      case (c)
        0: begin
          n_cmp++; if (bus.div_start !== 1'b1 || bus.pipe_issue !== 1'b0) begin n_bad++; $display("FAIL div_start got %b/%b want 1/0", bus.div_start, bus.pipe_issue); end
        end
        1: begin
          n_cmp++; if (bus.in_ready !== 1'b1 || bus.pipe_issue !== 1'b1) begin n_bad++; $display("FAIL div_pipe_issue got %b/%b want 1/1", bus.in_ready, bus.pipe_issue); end
        end
        5: begin
          n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd6 || bus.wb_data !== 32'hADD0_0006) begin n_bad++; $display("FAIL div_pipe_first got v=%b rd=%0d d=%h want 1/6/add00006", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        end
        6: begin
          n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'hD1D1_0005) begin n_bad++; $display("FAIL div_buffered got v=%b rd=%0d d=%h want 1/5/d1d10005", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        end
        7: begin
          n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL div_drained got %b want 0", bus.wb_valid); end
          n_cmp++; if (bus.csr_rdata !== 32'h0000_0009) begin n_bad++; $display("FAIL div_fflags got %h want 00000009", bus.csr_rdata); end
        end
        default: begin
          n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL div_idle_wb[%0d] got %b want 0", c, bus.wb_valid); end
        end
      endcase
      tick();
    end
  endtask

  // FMUL to the same rd as an in-flight FDIV stalls until the div writes back.
  task automatic test_waw_stall();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 0) set_op(OPC_FP, F7_DIV, 3'b000, 5'd5);
      if (c >= 1 && c <= 4) set_op(OPC_FP, F7_MUL, 3'b000, 5'd5);
      if (c == 3) begin
        bus.div_done   = 1'b1;
        bus.div_result = 32'h5555_0005;
      end
      if (c == 8) bus.pipe_result = 32'h6666_0005;
      #1;
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.pipe_issue !== 1'b0) begin n_bad++; $display("FAIL waw_stall[%0d] got rdy=%b iss=%b want 0/0", c, bus.in_ready, bus.pipe_issue); end
      end
      if (c == 3) begin
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'h5555_0005) begin n_bad++; $display("FAIL waw_div_wb got v=%b rd=%0d d=%h want 1/5/55550005", bus.wb_valid, bus.wb_rd, bus.wb_data); end
      end
      if (c == 4) begin
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.pipe_issue !== 1'b1) begin n_bad++; $display("FAIL waw_release got rdy=%b iss=%b want 1/1", bus.in_ready, bus.pipe_issue); end
      end
      if (c == 8) begin
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'h6666_0005) begin n_bad++; $display("FAIL waw_mul_wb got v=%b rd=%0d d=%h want 1/5/66660005", bus.wb_valid, bus.wb_rd, bus.wb_data); end
      end
      tick();
    end
  endtask
`else
  // Without the div path, FDIV/FSQRT are illegal and div_done is ignored.
  task automatic test_div_disabled();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) set_op(OPC_FP, F7_DIV, 3'b000, 5'd5);
      if (c == 1) set_op(OPC_FP, F7_SQRT, 3'b000, 5'd6);
      if (c >= 2) begin
        bus.div_done   = 1'b1;
        bus.div_result = 32'hDEAD_BEEF;
      end
      #1;
      if (c < 2) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.illegal !== 1'b1 || bus.div_start !== 1'b0 || bus.pipe_issue !== 1'b0) begin
          n_bad++;
          $display("FAIL nodiv_illegal[%0d] got rdy=%b ill=%b ds=%b iss=%b want 1/1/0/0", c, bus.in_ready, bus.illegal, bus.div_start, bus.pipe_issue);
        end
      end else begin
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL nodiv_wb[%0d] got %b want 0", c, bus.wb_valid); end
      end
      tick();
    end
    bus.csr_addr = 12'h001;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'd0) begin n_bad++; $display("FAIL nodiv_fflags got %h want 0", bus.csr_rdata); end
  endtask
`endif

  // frm=101 makes a dynamic-rm op illegal; bad rm and opcodes are illegal too.
  task automatic test_illegal();
    idle_inputs();
    bus.csr_wr_en = 1'b1;
    bus.csr_addr  = 12'h002;
    bus.csr_wdata = 32'h0000_0005;
    tick();
    idle_inputs();
    bus.csr_addr = 12'h002;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0005) begin n_bad++; $display("FAIL ill_frm_read got %h want 00000005", bus.csr_rdata); end
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c == 0) set_op(OPC_FP, F7_ADD, 3'b111, 5'd3);
      if (c == 2) set_op(OPC_FP, F7_ADD, 3'b110, 5'd3);
      if (c == 3) set_op(OPC_BAD, F7_ADD, 3'b000, 5'd3);
      #1;
      if (c == 0 || c == 2 || c == 3) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.illegal !== 1'b1 || bus.pipe_issue !== 1'b0) begin
          n_bad++;
          $display("FAIL ill_op[%0d] got rdy=%b ill=%b iss=%b want 1/1/0", c, bus.in_ready, bus.illegal, bus.pipe_issue);
        end
      end else begin
        n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL ill_pulse[%0d] got %b want 0", c, bus.illegal); end
      end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL ill_wb[%0d] got %b want 0", c, bus.wb_valid); end
      tick();
    end
    idle_inputs();
    bus.csr_wr_en = 1'b1;
    bus.csr_addr  = 12'h002;
    bus.csr_wdata = 32'h0000_0000;
    tick();
    idle_inputs();
    set_op(OPC_FP, F7_ADD, 3'b111, 5'd3);
    #1;
    n_cmp++; if (bus.illegal !== 1'b0 || bus.pipe_issue !== 1'b1) begin n_bad++; $display("FAIL ill_frm_ok got ill=%b iss=%b want 0/1", bus.illegal, bus.pipe_issue); end
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
  endtask

  // A CSR write to fflags coincides with a writeback carrying NX.
  task automatic test_csr_flags();
    idle_inputs();
    bus.csr_wr_en = 1'b1;
    bus.csr_addr  = 12'h001;
    bus.csr_wdata = 32'd0;
    tick();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin
        set_op(OPC_FP, F7_ADD, 3'b000, 5'd7);
        bus.csr_wr_en = 1'b1;
        bus.csr_addr  = 12'h002;
        bus.csr_wdata = 32'h0000_0002;
      end
      if (c == 4) begin
        bus.pipe_result = 32'h4000_0007;
        bus.pipe_flags  = 5'b00001;
        bus.csr_wr_en   = 1'b1;
        bus.csr_addr    = 12'h001;
        bus.csr_wdata   = 32'h0000_0010;
      end
      #1;
      if (c == 4) begin
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7) begin n_bad++; $display("FAIL csr_wb got v=%b rd=%0d want 1/7", bus.wb_valid, bus.wb_rd); end
      end
      tick();
    end
    idle_inputs();
    bus.csr_addr = 12'h001;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0011) begin n_bad++; $display("FAIL csr_fflags got %h want 00000011", bus.csr_rdata); end
    bus.csr_addr = 12'h003;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0051) begin n_bad++; $display("FAIL csr_fcsr got %h want 00000051", bus.csr_rdata); end
    bus.csr_wr_en = 1'b1;
    bus.csr_addr  = 12'h004;
    bus.csr_wdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    bus.csr_addr = 12'h004;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'd0) begin n_bad++; $display("FAIL csr_unmapped got %h want 0", bus.csr_rdata); end
    bus.csr_addr = 12'h003;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0051) begin n_bad++; $display("FAIL csr_fcsr_kept got %h want 00000051", bus.csr_rdata); end
    bus.csr_wr_en = 1'b1;
    bus.csr_wdata = 32'h0000_00E5;
    tick();
    idle_inputs();
    bus.csr_addr = 12'h003;
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0000_00E5) begin n_bad++; $display("FAIL csr_fcsr_wr got %h want 000000e5", bus.csr_rdata); end
    bus.csr_wr_en = 1'b1;
    bus.csr_wdata = 32'h0000_0000;
    tick();
    idle_inputs();
  endtask

  // Reset with a busy div (when enabled) and a full pipe.
  // Nothing may be written back afterwards.
  task automatic test_reset_midop();
    int first;
`ifdef RV32F_SCHED_DIVSQRT_EN
    first = 1;
`else
    first = 0;
`endif
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
`ifdef RV32F_SCHED_DIVSQRT_EN
      if (c == 0) set_op(OPC_FP, F7_DIV, 3'b000, 5'd9);
`endif
      if (c >= first && c < first + 4) set_op(OPC_FP, F7_ADD, 3'b000, 5'(10 + c - first));
      if (c == first + 4) rst = 1'b0;
      if (c == first + 5) begin
        rst = 1'b1;
        bus.div_done = 1'b1;
`ifdef RV32F_SCHED_DIVSQRT_EN
        bus.in_opcode = OPC_FP;
        bus.in_funct7 = F7_DIV;
        bus.in_rd     = 5'd9;
`else
        bus.in_opcode = OPC_FP;
        bus.in_funct7 = F7_ADD;
        bus.in_rd     = 5'd10;
`endif
      end
      if (c == first + 6) bus.div_done = 1'b1;
      bus.pipe_result = 32'hBAD0_0000;
      #1;
      if (c >= first && c < first + 4) begin
        n_cmp++; if (bus.pipe_issue !== 1'b1) begin n_bad++; $display("FAIL rmid_issue[%0d] got %b want 1", c, bus.pipe_issue); end
      end
      if (c == first + 4) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_ready got %b want 0", bus.in_ready); end
      end
      if (c == first + 5) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", bus.in_ready); end
      end
      if (c >= first + 4) begin
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_wb[%0d] got %b want 0", c, bus.wb_valid); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
`ifdef RV32F_SCHED_DIVSQRT_EN
    test_div_collision();
    test_waw_stall();
`else
    test_div_disabled();
`endif
    test_illegal();
    test_csr_flags();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
